// File: rtl/crc_stream_dec.sv
// Streaming CRC checker: passes beats through a single register stage while
// folding each beat into a running remainder, and tags the last beat of each
// frame with the final remainder and a pass/fail flag. Also keeps saturating
// counts of checked and failed frames.
module crc_stream_dec #(
    parameter int                DATA_W = 8,
    parameter int                CRC_W  = 9,
    parameter logic [CRC_W-1:0]  POLY   = 9'h0AF,
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              m_haserr,
    output logic [CRC_W-1:0]  m_syndrome,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              state_q;
    logic [CRC_W-1:0]    r_q;
    logic [CRC_W-1:0]    rem_d;
    logic [CRC_W-1:0]    seed;
    logic                m_valid_q;
    logic [DATA_W-1:0]   m_data_q;
    logic                m_last_q;
    logic                m_haserr_q;
    logic [CRC_W-1:0]    m_syndrome_q;
    logic [CNT_W-1:0]    frame_cnt_q;
    logic [CNT_W-1:0]    err_cnt_q;
    logic                in_xfer;
    logic                out_xfer;

    // Fold one beat into a remainder, MSB of the beat first.
    function automatic logic [CRC_W-1:0] crc_beat(input logic [CRC_W-1:0] r_in,
                                                  input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = r_in;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = r[CRC_W-1] ^ d[i];
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return r;
    endfunction

    assign s_ready  = !m_valid_q | m_ready;
    assign in_xfer  = s_valid & s_ready;
    assign out_xfer = m_valid_q & m_ready;

    // Running remainder including the beat currently offered; a new frame
    // always starts from zero, whatever r_q holds.
    always_comb begin
        seed  = (state_q == IDLE) ? '0 : r_q;
        rem_d = crc_beat(seed, s_data);
    end

    // Frame FSM, remainder register and registered output stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            r_q          <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            m_haserr_q   <= 1'b0;
            m_syndrome_q <= '0;
        end else if (in_xfer) begin
            m_valid_q <= 1'b1;
            m_data_q  <= s_data;
            m_last_q  <= s_last;
            if (s_last) begin
                m_haserr_q   <= |rem_d;
                m_syndrome_q <= rem_d;
                r_q          <= '0;
                state_q      <= IDLE;
            end else begin
                m_haserr_q   <= 1'b0;
                m_syndrome_q <= '0;
                r_q          <= rem_d;
                state_q      <= IN_FRAME;
            end
        end else if (out_xfer) begin
            m_valid_q <= 1'b0;
        end
    end

    // Saturating frame/error statistics; a clear wins over a same-cycle count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (clr_cnt) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (in_xfer && s_last) begin
            if (frame_cnt_q != CNT_MAX) begin
                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end
            if ((rem_d != '0) && (err_cnt_q != CNT_MAX)) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_last     = m_last_q;
    assign m_haserr   = m_haserr_q;
    assign m_syndrome = m_syndrome_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_crc_stream_dec.sv
// Bench for crc_stream_dec: table-driven frames plus hand sequences for
// backpressure, mid-frame reset, counter saturation and clear.
module tb_crc_stream_dec;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             s_valid;
    logic             s_ready;
    logic [7:0]       s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [7:0]       m_data;
    logic             m_last;
    logic             m_haserr;
    logic [8:0]       m_syndrome;
    logic             clr_cnt;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] err_cnt;

    crc_stream_dec #(
        .DATA_W (8),
        .CRC_W  (9),
        .POLY   (9'h0AF),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_haserr   (m_haserr),
        .m_syndrome (m_syndrome),
        .clr_cnt    (clr_cnt),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       err;
        logic [8:0] syn;
    } vec_t;

    vec_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic toggle_en = 1'b0;
    logic [3:0] rdy_pat = 4'b1001;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference bit-serial CRC over a bit string, used only to build a codeword.
    function automatic logic [8:0] ref_crc23(input logic [22:0] msg);
        logic [8:0] r;
        logic       fb;
        r = '0;
        for (int i = 22; i >= 0; i--) begin
            fb = r[8] ^ msg[i];
            r  = {r[7:0], 1'b0} ^ (fb ? 9'h0AF : 9'h000);
        end
        return r;
    endfunction

    // Downstream ready: always 1 unless the 1,0,0,1 toggle pattern is enabled.
    initial begin
        int idx;
        idx = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) begin
                m_ready = rdy_pat[3 - idx];
                idx = (idx + 1) % 4;
            end else begin
                m_ready = 1'b1;
                idx = 0;
            end
        end
    end

    // Output monitor: scoreboard compare on each output transfer, and
    // stability check of every m_* signal across stalled cycles.
    initial begin
        vec_t       e;
        logic       prev_stall;
        logic [7:0] h_data;
        logic       h_last;
        logic       h_err;
        logic [8:0] h_syn;
        prev_stall = 1'b0;
        h_data = '0; h_last = 1'b0; h_err = 1'b0; h_syn = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", {31'd0, m_valid}, 32'd1);
                    chk("stall_hold", {m_data, m_last, m_haserr, m_syndrome},
                        {h_data, h_last, h_err, h_syn});
                end
                if (m_valid && m_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 32'd0, 32'd1);
                    end else begin
                        e = sb.pop_front();
                        chk("m_data", {24'd0, m_data}, {24'd0, e.data});
                        chk("m_last", {31'd0, m_last}, {31'd0, e.last});
                        if (e.last) begin
                            chk("m_haserr", {31'd0, m_haserr}, {31'd0, e.err});
                            chk("m_syndrome", {23'd0, m_syndrome}, {23'd0, e.syn});
                        end
                    end
                end
                prev_stall = m_valid && !m_ready;
                h_data = m_data; h_last = m_last; h_err = m_haserr; h_syn = m_syndrome;
            end
        end
    end

    // Offer one beat; the expected output record is queued once acceptance is seen.
    task automatic send_beat(input logic [7:0] d, input logic l,
                             input logic e, input logic [8:0] syn);
        int   n;
        vec_t v;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL s_ready_timeout: got 0 expected 1 at %0t", $time);
        end
        v.data = d; v.last = l; v.err = e; v.syn = syn;
        sb.push_back(v);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain", sb.size(), 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        sb.delete();
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_outs", {m_data, m_last, m_haserr, m_syndrome}, 32'd0);
        chk("rst_cnts", {frame_cnt, err_cnt}, 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t       tbl[10];
        logic [22:0] msg;
        logic [31:0] cw;
        logic [7:0]  b;

        tbl[0] = '{8'h01, 1'b1, 1'b1, 9'h0AF};
        tbl[1] = '{8'h02, 1'b1, 1'b1, 9'h15E};
        tbl[2] = '{8'h04, 1'b1, 1'b1, 9'h013};
        tbl[3] = '{8'h80, 1'b1, 1'b1, 9'h0CF};
        tbl[4] = '{8'h00, 1'b0, 1'b0, 9'h000};
        tbl[5] = '{8'h00, 1'b0, 1'b0, 9'h000};
        tbl[6] = '{8'h00, 1'b0, 1'b0, 9'h000};
        tbl[7] = '{8'h00, 1'b1, 1'b0, 9'h000};
        tbl[8] = '{8'h00, 1'b0, 1'b0, 9'h000};
        tbl[9] = '{8'h80, 1'b1, 1'b1, 9'h0CF};

        reset = 1'b1;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; clr_cnt = 1'b0;
        #2;
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_outs", {m_data, m_last, m_haserr, m_syndrome}, 32'd0);
        chk("rst_cnts", {frame_cnt, err_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);

        // Clean two-beat zero frame.
        send_beat(8'h00, 1'b0, 1'b0, 9'h000);
        send_beat(8'h00, 1'b1, 1'b0, 9'h000);
        drain();
        chk("zero_frame_cnt", {28'd0, frame_cnt}, 32'd1);
        chk("zero_err_cnt", {28'd0, err_cnt}, 32'd0);

        // Two-beat frame ending in a single 1 bit.
        send_beat(8'h00, 1'b0, 1'b0, 9'h000);
        send_beat(8'h01, 1'b1, 1'b1, 9'h0AF);
        drain();
        chk("err_frame_cnt", {28'd0, frame_cnt}, 32'd2);
        chk("err_err_cnt", {28'd0, err_cnt}, 32'd1);

        // Table of frames, back to back.
        for (int i = 0; i < 10; i++) begin
            send_beat(tbl[i].data, tbl[i].last, tbl[i].err, tbl[i].syn);
        end
        drain();
        chk("tbl_frame_cnt", {28'd0, frame_cnt}, 32'd8);
        chk("tbl_err_cnt", {28'd0, err_cnt}, 32'd6);

        // Valid 4-beat codeword under 1,0,0,1 backpressure.
        msg = 23'h5A3C71;
        cw  = {msg, ref_crc23(msg)};
        toggle_en = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            b = cw[i*8 +: 8];
            send_beat(b, (i == 0), 1'b0, 9'h000);
        end
        drain();
        toggle_en = 1'b0;
        chk("cw_frame_cnt", {28'd0, frame_cnt}, 32'd9);
        chk("cw_err_cnt", {28'd0, err_cnt}, 32'd6);

        // Reset in the middle of a frame with a non-zero running remainder.
        send_beat(8'hFF, 1'b0, 1'b0, 9'h000);
        send_beat(8'hA5, 1'b0, 1'b0, 9'h000);
        pulse_reset();
        send_beat(8'h00, 1'b0, 1'b0, 9'h000);
        send_beat(8'h00, 1'b1, 1'b0, 9'h000);
        drain();
        chk("postrst_frame_cnt", {28'd0, frame_cnt}, 32'd1);
        chk("postrst_err_cnt", {28'd0, err_cnt}, 32'd0);

        // Drive frame_cnt to saturation and beyond.
        for (int i = 0; i < 15; i++) begin
            send_beat(8'h00, 1'b1, 1'b0, 9'h000);
        end
        drain();
        chk("sat_frame_cnt", {28'd0, frame_cnt}, 32'd15);
        send_beat(8'h01, 1'b1, 1'b1, 9'h0AF);
        drain();
        chk("sat_hold_frame_cnt", {28'd0, frame_cnt}, 32'd15);
        chk("sat_err_cnt", {28'd0, err_cnt}, 32'd1);

        // Clear coinciding with a failing last beat: that frame is not counted.
        clr_cnt = 1'b1;
        send_beat(8'h01, 1'b1, 1'b1, 9'h0AF);
        clr_cnt = 1'b0;
        chk("clr_frame_cnt", {28'd0, frame_cnt}, 32'd0);
        chk("clr_err_cnt", {28'd0, err_cnt}, 32'd0);
        drain();
        send_beat(8'h02, 1'b1, 1'b1, 9'h15E);
        drain();
        chk("after_clr_frame_cnt", {28'd0, frame_cnt}, 32'd1);
        chk("after_clr_err_cnt", {28'd0, err_cnt}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/crc_stream_dec.md
CRC_STREAM_DEC -- requirements
Module: crc_stream_dec

Interface
REQ-001 Parameter DATA_W, default 8, bits per input beat (1..64).
REQ-002 Parameter CRC_W, default 9, CRC width (2..32).
REQ-003 Parameter POLY, default 9'h0AF, generator polynomial low CRC_W bits; x^CRC_W term implicit.
REQ-004 Parameter CNT_W, default 16, width of the statistics counters.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 s_valid  in  1  input beat valid.
REQ-008 s_ready  out  1  block accepts an input beat this cycle.
REQ-009 s_data  in  DATA_W  codeword beat; bit DATA_W-1 is first on the wire.
REQ-010 s_last  in  1  beat is the final beat of a codeword frame.
REQ-011 m_valid  out  1  output beat valid.
REQ-012 m_ready  in  1  downstream accepts the output beat.
REQ-013 m_data  out  DATA_W  registered copy of the accepted input beat.
REQ-014 m_last  out  1  output beat ends a frame.
REQ-015 m_haserr  out  1  frame failed its CRC check; meaningful only when m_valid and m_last.
REQ-016 m_syndrome  out  CRC_W  final frame remainder; meaningful only when m_valid and m_last.
REQ-017 clr_cnt  in  1  synchronous clear of both counters.
REQ-018 frame_cnt  out  CNT_W  number of frames checked.
REQ-019 err_cnt  out  CNT_W  number of frames with m_haserr=1.

Function
REQ-020 An input transfer occurs when s_valid and s_ready are both 1; an output transfer occurs when m_valid and m_ready are both 1.
REQ-021 s_ready shall equal (!m_valid | m_ready), giving a single-register pipeline with one-cycle latency and full throughput.
REQ-022 Remainder register r[CRC_W-1:0] is 0 at frame start and is updated once per input transfer, bit-serially over the beat MSB first.
REQ-023 Per-bit update: fb = r[CRC_W-1] ^ b; r = (r<<1) ^ (fb ? POLY : 0), truncated to CRC_W bits.
REQ-024 The frame remainder is the r value after the s_last beat's update; the frame passes iff that remainder is 0.
REQ-025 On a transfer with s_last=1: m_syndrome and m_haserr load from the frame remainder, and r returns to 0 for the next frame in the same cycle.
REQ-026 On a transfer with s_last=0: m_haserr=0 and m_syndrome=0 are loaded, and r holds the running remainder.
REQ-027 FSM IDLE/IN_FRAME: IDLE->IN_FRAME on a non-last transfer; IN_FRAME->IDLE on a last transfer; a single-beat frame stays in IDLE.
REQ-028 m_valid sets on an input transfer, clears on an output transfer without a new input, and stays 1 on simultaneous output and input transfers.
REQ-029 While m_valid=1 and m_ready=0, all m_* outputs shall hold stable.
REQ-030 On an input transfer with s_last=1: frame_cnt increments, and err_cnt increments if the remainder is non-zero; both saturate at all-ones.
REQ-031 clr_cnt=1 zeroes both counters; clear takes priority over a same-cycle increment, and that frame is not counted.
REQ-032 The block has no frame timeout; a frame with unbounded length is accepted.

Reset
REQ-033 reset=1 drives asynchronously: m_valid=0, m_data=0, m_last=0, m_haserr=0, m_syndrome=0, r=0, FSM=IDLE, frame_cnt=0, err_cnt=0.
REQ-034 A partial frame in progress at reset is discarded; the first beat after reset starts a new frame.

Verification
REQ-035 Bench: 2-beat frame 8'h00, 8'h00 (last) -> second output beat m_last=1, m_haserr=0, m_syndrome=9'h000; frame_cnt=1, err_cnt=0.
REQ-036 Bench: 2-beat frame 8'h00, 8'h01 (last) -> m_haserr=1, m_syndrome=9'h0AF; err_cnt=1.
REQ-037 Bench: a valid codeword from the Python reference model is streamed while m_ready toggles 1,0,0,1 -> no beat is lost or duplicated, m_* are stable while stalled, m_haserr=0.
REQ-038 Bench: reset is asserted mid-frame, then a clean 2-beat zero frame is sent -> m_haserr=0, frame_cnt=1.
REQ-039 Bench: frame_cnt is preset to all-ones via traffic, then another frame is sent -> frame_cnt stays all-ones; clr_cnt is pulsed with a last beat in the same cycle -> both counters read 0.
